vline_fetch: RTL and testbench

- Memory-clock line fetcher that fills the 512x12 video line buffer ahead of the video-out reader.
- On each line request it clears the buffer write pointer, issues fixed-length burst reads to the frame-memory read port, and streams returned pixels into the buffer as write strobes.
- Tracks the frame line address, with restart at frame start.

---
 rtl/vline_fetch.sv | 143 ++++++++++++++
 tb/tb_vline_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vline_fetch.sv
// Memory-clock line fetcher: issues fixed-length burst reads for one video line
// and streams the returned pixels into the line buffer as registered write strobes.
module vline_fetch #(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned LINE_PIXELS = 320,
    parameter int unsigned BURST_LEN   = 32,
    parameter int unsigned LINE_STRIDE = 320,
    parameter int unsigned FRAME_BASE  = 0
) (
    input  logic              i_clk_mem,
    input  logic              i_reset,
    input  logic              i_frame_start,
    input  logic              i_line_req,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic              i_rd_valid,
    input  logic [11:0]       i_rd_data,
    output logic              o_vdata_reset,
    output logic              o_vdata_valid,
    output logic [11:0]       o_vdata,
    output logic              o_busy,
    output logic              o_line_done,
    output logic              o_overrun
);

    localparam int unsigned PIX_W  = 10;
    localparam int unsigned BEAT_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        REQ,
        DATA,
        DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  line_addr;
    logic [PIX_W-1:0]   pix_cnt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [PIX_W-1:0]   pix_next;

    assign pix_next = pix_cnt + PIX_W'(1);

    always_ff @(posedge i_clk_mem) begin
        if (i_reset) begin
            state         <= IDLE;
            line_addr     <= ADDR_W'(FRAME_BASE);
            pix_cnt       <= '0;
            beat_cnt      <= '0;
            o_rd_req      <= 1'b0;
            o_rd_addr     <= '0;
            o_vdata_reset <= 1'b0;
            o_vdata_valid <= 1'b0;
            o_vdata       <= '0;
            o_busy        <= 1'b0;
            o_line_done   <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_vdata_reset <= 1'b0;
            o_vdata_valid <= 1'b0;
            o_line_done   <= 1'b0;
            o_overrun     <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_line_req) begin
                        state         <= CLEAR;
                        pix_cnt       <= '0;
                        o_vdata_reset <= 1'b1;
                        o_busy        <= 1'b1;
                    end
                end
                CLEAR: begin
                    state     <= REQ;
                    o_rd_req  <= 1'b1;
                    o_rd_addr <= line_addr + ADDR_W'(pix_cnt);
                end
                REQ: begin
                    if (i_rd_ack) begin
                        state    <= DATA;
                        o_rd_req <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    // The burst ends on its last accepted beat, so the next request
                    // rises one cycle later, in parallel with the final write strobe.
                    if (i_rd_valid) begin
                        o_vdata_valid <= 1'b1;
                        o_vdata       <= i_rd_data;
                        beat_cnt      <= beat_cnt + BEAT_W'(1);
                        pix_cnt       <= pix_next;
                        if (beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
                            if (pix_next == PIX_W'(LINE_PIXELS)) begin
                                state       <= DONE;
                                o_line_done <= 1'b1;
                            end else begin
                                state     <= REQ;
                                o_rd_req  <= 1'b1;
                                o_rd_addr <= line_addr + ADDR_W'(pix_next);
                            end
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    line_addr <= line_addr + ADDR_W'(LINE_STRIDE);
                    o_busy    <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            if (i_line_req && state != IDLE) begin
                o_overrun <= 1'b1;
            end

            // Frame restart overrides everything above except a write strobe already
            // captured this cycle; a simultaneous line request is then taken from IDLE.
            if (i_frame_start) begin
                line_addr   <= ADDR_W'(FRAME_BASE);
                pix_cnt     <= '0;
                beat_cnt    <= '0;
                o_rd_req    <= 1'b0;
                o_line_done <= 1'b0;
                o_overrun   <= 1'b0;
                if (i_line_req) begin
                    state         <= CLEAR;
                    o_vdata_reset <= 1'b1;
                    o_busy        <= 1'b1;
                end else begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vline_fetch.sv
// Directed bench for vline_fetch: a scripted frame-memory model serves bursts while
// a passive monitor tallies buffer writes, clears, line-done and overrun pulses.
module tb_vline_fetch;

    logic        clk;
    logic        i_reset;
    logic        i_frame_start;
    logic        i_line_req;
    logic        o_rd_req;
    logic [21:0] o_rd_addr;
    logic        i_rd_ack;
    logic        i_rd_valid;
    logic [11:0] i_rd_data;
    logic        o_vdata_reset;
    logic        o_vdata_valid;
    logic [11:0] o_vdata;
    logic        o_busy;
    logic        o_line_done;
    logic        o_overrun;
    logic [39:0] all_outs;

    int errors = 0;
    int checks = 0;

    int strobes = 0, vresets = 0, dones = 0, overruns = 0, order_err = 0, line_strobes = 0;
    int s_str, s_vr, s_dn, s_ov;

    vline_fetch #(
        .ADDR_W(22),
        .LINE_PIXELS(320),
        .BURST_LEN(32),
        .LINE_STRIDE(320),
        .FRAME_BASE(0)
    ) dut (
        .i_clk_mem(clk),
        .i_reset(i_reset),
        .i_frame_start(i_frame_start),
        .i_line_req(i_line_req),
        .o_rd_req(o_rd_req),
        .o_rd_addr(o_rd_addr),
        .i_rd_ack(i_rd_ack),
        .i_rd_valid(i_rd_valid),
        .i_rd_data(i_rd_data),
        .o_vdata_reset(o_vdata_reset),
        .o_vdata_valid(o_vdata_valid),
        .o_vdata(o_vdata),
        .o_busy(o_busy),
        .o_line_done(o_line_done),
        .o_overrun(o_overrun)
    );

    assign all_outs = {o_rd_req, o_rd_addr, o_vdata_reset, o_vdata_valid, o_vdata,
                       o_busy, o_line_done, o_overrun};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each line's strobes must carry pixel indices 0,1,2,... counted from its clear.
    always @(negedge clk) begin
        if (o_vdata_valid === 1'b1) begin
            if (o_vdata !== 12'(line_strobes)) order_err++;
            line_strobes++;
            strobes++;
        end
        if (o_vdata_reset === 1'b1) begin
            line_strobes = 0;
            vresets++;
        end
        if (o_line_done === 1'b1) dones++;
        if (o_overrun === 1'b1) overruns++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        s_str = strobes;
        s_vr  = vresets;
        s_dn  = dones;
        s_ov  = overruns;
    endtask

    task automatic pulse_line_req();
        i_line_req = 1'b1;
        @(negedge clk);
        i_line_req = 1'b0;
    endtask

    // ev_kind: 0 none, 1 frame_start abort (model keeps sending), 2 frame_start+line_req,
    // 3 reset. The event is driven alongside beat ev_beat of burst ev_burst.
    task automatic run_line(input logic [21:0] base, input int ack_dly, input int gap,
                            input int lr_burst, input int ev_burst, input int ev_beat,
                            input int ev_kind);
        bit aborted = 0;
        for (int b = 0; b < 10; b++) begin
            int t = 0;
            int unstable = 0;
            logic [21:0] a;
            while (o_rd_req !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("req_seen_b%0d", b), o_rd_req, 1);
            if (o_rd_req !== 1'b1) return;
            a = base + 22'(32 * b);
            chk($sformatf("rd_addr_b%0d", b), o_rd_addr, a);
            for (int k = 0; k < ack_dly; k++) begin
                @(negedge clk);
                if (o_rd_req !== 1'b1 || o_rd_addr !== a) unstable++;
            end
            if (ack_dly > 3) chk($sformatf("addr_stable_b%0d", b), unstable, 0);
            i_rd_ack = 1'b1;
            @(negedge clk);
            i_rd_ack = 1'b0;
            for (int j = 0; j < 32; j++) begin
                bit ev;
                repeat (gap) @(negedge clk);
                ev = (!aborted && b == ev_burst && j == ev_beat);
                i_rd_valid = 1'b1;
                i_rd_data  = 12'(32 * b + j);
                if (b == lr_burst && j == 5) i_line_req = 1'b1;
                if (ev) begin
                    i_frame_start = (ev_kind == 1 || ev_kind == 2);
                    i_line_req    = i_line_req | (ev_kind == 2);
                    i_reset       = (ev_kind == 3);
                end
                @(negedge clk);
                i_rd_valid    = 1'b0;
                i_line_req    = 1'b0;
                i_frame_start = 1'b0;
                i_reset       = 1'b0;
                if (ev) begin
                    aborted = 1;
                    if (ev_kind == 1) begin
                        chk("abort_rd_req_low", o_rd_req, 0);
                        chk("abort_busy_low", o_busy, 0);
                    end else if (ev_kind == 2) begin
                        chk("restart_no_overrun", o_overrun, 0);
                        chk("restart_clear", o_vdata_reset, 1);
                        chk("restart_busy", o_busy, 1);
                        return;
                    end else begin
                        chk("midburst_reset_outs", all_outs, 0);
                        return;
                    end
                end
            end
            if (aborted) return;
        end
    endtask

    initial begin
        i_reset = 1'b1; i_frame_start = 1'b0; i_line_req = 1'b0;
        i_rd_ack = 1'b0; i_rd_valid = 1'b0; i_rd_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs, 0);
        i_reset = 1'b0;
        @(negedge clk);
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
        settle(2);

        // Line 0: plain fetch from FRAME_BASE
        snap();
        pulse_line_req();
        chk("clear_pulse", o_vdata_reset, 1);
        chk("busy_in_clear", o_busy, 1);
        run_line(22'd0, 3, 0, -1, -1, 0, 0);
        settle(4);
        chk("l0_strobes", strobes - s_str, 320);
        chk("l0_clears", vresets - s_vr, 1);
        chk("l0_done", dones - s_dn, 1);
        chk("l0_order", order_err, 0);
        chk("l0_idle", o_busy, 0);

        // Line 1 at stride 320
        snap();
        pulse_line_req();
        run_line(22'd320, 3, 0, -1, -1, 0, 0);
        settle(4);
        chk("l1_strobes", strobes - s_str, 320);
        chk("l1_done", dones - s_dn, 1);

        // Line 2 at 640 with a line request during burst 4
        snap();
        pulse_line_req();
        run_line(22'd640, 3, 0, 3, -1, 0, 0);
        settle(4);
        chk("l2_overrun", overruns - s_ov, 1);
        chk("l2_strobes", strobes - s_str, 320);
        chk("l2_clears", vresets - s_vr, 1);
        chk("l2_order", order_err, 0);

        // Line 3 at 960: ack withheld 20 cycles, data on 1 of 3 cycles
        snap();
        pulse_line_req();
        run_line(22'd960, 20, 2, -1, -1, 0, 0);
        settle(4);
        chk("l3_strobes", strobes - s_str, 320);
        chk("l3_order", order_err, 0);
        chk("l3_done", dones - s_dn, 1);

        // Line 4 at 1280: frame_start on beat 10 of burst 5, model keeps sending
        snap();
        pulse_line_req();
        run_line(22'd1280, 3, 0, -1, 4, 10, 1);
        settle(6);
        chk("abort_strobes", strobes - s_str, 4 * 32 + 11);
        chk("abort_no_done", dones - s_dn, 0);
        chk("abort_idle", o_busy, 0);

        // After abort the next line restarts at FRAME_BASE
        snap();
        pulse_line_req();
        run_line(22'd0, 3, 0, -1, -1, 0, 0);
        settle(4);
        chk("post_abort_strobes", strobes - s_str, 320);
        chk("post_abort_order", order_err, 0);

        // frame_start + line_req together while busy on line at 320
        snap();
        pulse_line_req();
        run_line(22'd320, 3, 0, -1, 1, 3, 2);
        run_line(22'd0, 3, 0, -1, -1, 0, 0);
        settle(4);
        chk("restart_strobes", strobes - s_str, 36 + 320);
        chk("restart_clears", vresets - s_vr, 2);
        chk("restart_overruns", overruns - s_ov, 0);
        chk("restart_done", dones - s_dn, 1);
        chk("restart_order", order_err, 0);

        // Reset mid-DATA on line at 320, then fetch resumes from FRAME_BASE
        pulse_line_req();
        run_line(22'd320, 3, 0, -1, 2, 7, 3);
        settle(3);
        chk("post_reset_idle", all_outs, 0);
        snap();
        pulse_line_req();
        run_line(22'd0, 3, 0, -1, -1, 0, 0);
        settle(4);
        chk("post_reset_strobes", strobes - s_str, 320);
        chk("post_reset_done", dones - s_dn, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
